// File: rtl/steg_pkg.sv
// Shared definitions for the LSB steganography embedder/extractor pair:
// the common FSM encoding, default sizing constants and a clog2 helper.
package steg_pkg;

   typedef enum logic [1:0] {
      s_IDLE    = 2'b00,
      s_EXTRACT = 2'b01
   } state_t;

   localparam int DEFAULT_BPS       = 16;
   localparam int DEFAULT_WORD_SIZE = 8;

   // Ceiling log2, usable in parameter expressions; returns 0 for values <= 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/bit_extractor_seq_word_assembler.sv
// Packs a serial LSB-first bit stream into WORD_SIZE-bit words. Each
// completed word is published on word_o together with a one-cycle
// registered word_valid_o pulse; bit_count_o shows the partial fill level.
module word_assembler
   import steg_pkg::*;
#(
   parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
   localparam int CNT_W    = clog2(WORD_SIZE)
) (
   input  logic                 in_clk,
   input  logic                 in_rst,
   input  logic                 bit_i,
   input  logic                 bit_valid_i,
   input  logic                 clear_i,
   output logic [WORD_SIZE-1:0] word_o,
   output logic                 word_valid_o,
   output logic [CNT_W-1:0]     bit_count_o
);

   logic [WORD_SIZE-1:0] partial_q, partial_d;
   logic [WORD_SIZE-1:0] word_q, word_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 valid_q, valid_d;

   // Insert the incoming bit at the current fill position; on the last bit
   // the whole word is handed to the output register and the fill restarts.
   always_comb begin
      partial_d = partial_q;
      word_d    = word_q;
      count_d   = count_q;
      valid_d   = 1'b0;
      if (clear_i) begin
         partial_d = '0;
         count_d   = '0;
      end else if (bit_valid_i) begin
         partial_d[count_q] = bit_i;
         if (count_q == CNT_W'(WORD_SIZE - 1)) begin
            word_d    = partial_d;
            valid_d   = 1'b1;
            partial_d = '0;
            count_d   = '0;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         partial_q <= '0;
         word_q    <= '0;
         count_q   <= '0;
         valid_q   <= 1'b0;
      end else begin
         partial_q <= partial_d;
         word_q    <= word_d;
         count_q   <= count_d;
         valid_q   <= valid_d;
      end
   end

   assign word_o       = word_q;
   assign word_valid_o = valid_q;
   assign bit_count_o  = count_q;

endmodule

// File: rtl/bit_extractor_seq.sv
// Receive-side LSB extractor: captures a frame of FRAME_SIZE samples, then
// walks the samples one per cycle, feeding each sample's LSB into the word
// assembler, which emits packed message words.
module bit_extractor_seq
   import steg_pkg::*;
#(
   parameter int BPS        = DEFAULT_BPS,
   parameter int FRAME_SIZE = 1,
   parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
   localparam int CNT_W     = clog2(WORD_SIZE),
   localparam int IDX_W     = (FRAME_SIZE > 1) ? clog2(FRAME_SIZE) : 1
) (
   input  logic                      in_clk,
   input  logic                      in_rst,
   input  logic                      in_enable,
   input  logic [FRAME_SIZE*BPS-1:0] in_frame,
   input  logic                      in_clear,
   output logic                      out_ready,
   output logic [WORD_SIZE-1:0]      out_word,
   output logic                      out_word_valid,
   output logic [CNT_W-1:0]          out_bit_count
);

   state_t                    state_q, state_d;
   logic [FRAME_SIZE*BPS-1:0] frame_q, frame_d;
   logic [IDX_W-1:0]          idx_q, idx_d;

   logic [FRAME_SIZE-1:0]     sampleLsbs;
   logic                      extBit;
   logic                      extValid;
   logic                      asmClear;
   logic                      readyInt;
   logic                      unusedFrameBits;

   // Only the LSB of each captured sample carries message data.
   always_comb begin
      sampleLsbs = '0;
      for (int k = 0; k < FRAME_SIZE; k++) begin
         sampleLsbs[k] = frame_q[k*BPS];
      end
   end

   assign unusedFrameBits = ^frame_q;

   // Next-state logic: accept a frame when idle, then extract one sample
   // LSB per cycle until the last sample has been consumed.
   always_comb begin
      state_d  = state_q;
      frame_d  = frame_q;
      idx_d    = idx_q;
      readyInt = 1'b0;
      extBit   = 1'b0;
      extValid = 1'b0;
      asmClear = 1'b0;
      case (state_q)
         s_IDLE: begin
            readyInt = 1'b1;
            asmClear = in_clear;
            if (in_enable) begin
               frame_d = in_frame;
               idx_d   = '0;
               state_d = s_EXTRACT;
            end
         end
         s_EXTRACT: begin
            extBit   = sampleLsbs[idx_q];
            extValid = 1'b1;
            if (idx_q == IDX_W'(FRAME_SIZE - 1)) begin
               idx_d   = '0;
               state_d = s_IDLE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = s_IDLE;
         end
      endcase
   end

   // FSM state, frame capture and sample index with synchronous reset.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_q <= s_IDLE;
         frame_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         idx_q   <= idx_d;
      end
   end

   assign out_ready = readyInt;

   word_assembler #(
      .WORD_SIZE(WORD_SIZE)
   ) u_assembler (
      .in_clk      (in_clk),
      .in_rst      (in_rst),
      .bit_i       (extBit),
      .bit_valid_i (extValid),
      .clear_i     (asmClear),
      .word_o      (out_word),
      .word_valid_o(out_word_valid),
      .bit_count_o (out_bit_count)
   );

endmodule

// File: tb/tb_bit_extractor_seq.sv
// Self-checking bench for bit_extractor_seq. Instance A (4 samples/frame)
// is checked every cycle against a queue-based reference model; instance B
// (3 samples/frame) covers words that straddle frame boundaries.
module tb_bit_extractor_seq;

   localparam int BPS = 16;
   localparam int W   = 8;
   localparam int AF  = 4;
   localparam int BF  = 3;

   logic             clk;
   logic             rstA, enA, clrA;
   logic [AF*BPS-1:0] frameA;
   logic             readyA, validA;
   logic [W-1:0]     wordA;
   logic [2:0]       countA;

   logic             rstB, enB, clrB;
   logic [BF*BPS-1:0] frameB;
   logic             readyB, validB;
   logic [W-1:0]     wordB;
   logic [2:0]       countB;

   int checks = 0;
   int errors = 0;
   int bValidCount = 0;

   // Reference model state: remaining busy cycles, bits still to extract,
   // bits already collected into the partial word, last word and its pulse.
   int          mBusy = 0;
   bit          mPend[$];
   bit          mPart[$];
   logic [W-1:0] mWord = '0;
   bit          mValid = 1'b0;

   bit_extractor_seq #(.BPS(BPS), .FRAME_SIZE(AF), .WORD_SIZE(W)) dutA (
      .in_clk(clk), .in_rst(rstA), .in_enable(enA), .in_frame(frameA),
      .in_clear(clrA), .out_ready(readyA), .out_word(wordA),
      .out_word_valid(validA), .out_bit_count(countA)
   );

   bit_extractor_seq #(.BPS(BPS), .FRAME_SIZE(BF), .WORD_SIZE(W)) dutB (
      .in_clk(clk), .in_rst(rstB), .in_enable(enB), .in_frame(frameB),
      .in_clear(clrB), .out_ready(readyB), .out_word(wordB),
      .out_word_valid(validB), .out_bit_count(countB)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", tag, actual, expected);
      end
   endtask

   // Advance the model by one clock edge using the inputs presented to A.
   task automatic modelEdge();
      if (rstA) begin
         mBusy = 0;
         mPend.delete();
         mPart.delete();
         mWord  = '0;
         mValid = 1'b0;
      end else begin
         mValid = 1'b0;
         if (mBusy > 0) begin
            mPart.push_back(mPend.pop_front());
            mBusy--;
            if (mPart.size() == W) begin
               for (int i = 0; i < W; i++) mWord[i] = mPart[i];
               mValid = 1'b1;
               mPart.delete();
            end
         end else begin
            if (clrA) mPart.delete();
            if (enA) begin
               mPend.delete();
               for (int k = 0; k < AF; k++) mPend.push_back(frameA[k*BPS]);
               mBusy = AF;
            end
         end
      end
   endtask

   // One clock: edge, model update, then compare A against the model.
   task automatic applyStimulus();
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput("readyA", {31'd0, readyA}, {31'd0, (mBusy == 0)});
      checkOutput("validA", {31'd0, validA}, {31'd0, mValid});
      checkOutput("wordA", {24'd0, wordA}, {24'd0, mWord});
      checkOutput("countA", {29'd0, countA}, 32'(mPart.size()));
      if (validB === 1'b1) bValidCount++;
   endtask

   function automatic logic [15:0] sampleWithLsb(input bit lsb);
      logic [15:0] s;
      s = 16'($urandom);
      s[0] = lsb;
      return s;
   endfunction

   initial begin
      int acc;
      rstA = 1'b1; enA = 1'b1; clrA = 1'b0; frameA = {$urandom, $urandom};
      rstB = 1'b1; enB = 1'b1; clrB = 1'b0; frameB = 48'h1111_2222_3333;

      // Reset held two cycles with enable asserted.
      applyStimulus();
      applyStimulus();
      checkOutput("rstB_ready", {31'd0, readyB}, 32'd1);
      checkOutput("rstB_count", {29'd0, countB}, 32'd0);
      checkOutput("rstB_word", {24'd0, wordB}, 32'd0);
      rstA = 1'b0; enA = 1'b0; rstB = 1'b0; enB = 1'b0;
      applyStimulus();

      // Two frames forming one word 0x35.
      frameA = {16'h8000, 16'hFFFF, 16'h0002, 16'h1235};
      enA = 1'b1;
      applyStimulus();
      enA = 1'b0;
      frameA = {$urandom, $urandom};
      for (int i = 0; i < AF; i++) applyStimulus();
      frameA = {16'h0000, 16'h7FFE, 16'h0003, 16'h0001};
      enA = 1'b1;
      applyStimulus();
      enA = 1'b0;
      for (int i = 0; i < AF; i++) applyStimulus();
      checkOutput("t2_valid", {31'd0, validA}, 32'd1);
      checkOutput("t2_word", {24'd0, wordA}, 32'h35);
      applyStimulus();
      checkOutput("t2_pulse", {31'd0, validA}, 32'd0);

      // Enable held high: one accept per FRAME_SIZE+1 cycles.
      acc = 0;
      enA = 1'b1;
      for (int i = 0; i < 15; i++) begin
         frameA = {$urandom, $urandom};
         if (readyA === 1'b1) acc++;
         applyStimulus();
      end
      enA = 1'b0;
      checkOutput("t3_accepts", 32'(acc), 32'd3);
      for (int i = 0; i < AF + 1; i++) applyStimulus();

      // Clear stale bits, then two frames with LSBs 0,1,0,1,...
      clrA = 1'b1;
      applyStimulus();
      clrA = 1'b0;
      checkOutput("t5_cleared", {29'd0, countA}, 32'd0);
      for (int f = 0; f < 2; f++) begin
         frameA = {sampleWithLsb(1), sampleWithLsb(0), sampleWithLsb(1), sampleWithLsb(0)};
         enA = 1'b1;
         applyStimulus();
         enA = 1'b0;
         for (int i = 0; i < AF; i++) applyStimulus();
      end
      checkOutput("t5_word", {24'd0, wordA}, 32'hAA);

      // Reset in the middle of a frame.
      frameA = {$urandom, $urandom};
      enA = 1'b1;
      applyStimulus();
      enA = 1'b0;
      applyStimulus();
      rstA = 1'b1;
      applyStimulus();
      rstA = 1'b0;
      checkOutput("t6_ready", {31'd0, readyA}, 32'd1);
      checkOutput("t6_count", {29'd0, countA}, 32'd0);
      for (int f = 0; f < 2; f++) begin
         frameA = {$urandom, $urandom};
         enA = 1'b1;
         applyStimulus();
         enA = 1'b0;
         for (int i = 0; i < AF; i++) applyStimulus();
      end

      // Cross-boundary words on B: three frames of all-ones LSBs.
      bValidCount = 0;
      for (int f = 0; f < 3; f++) begin
         frameB = {sampleWithLsb(1), sampleWithLsb(1), sampleWithLsb(1)};
         checkOutput("t4_readyB", {31'd0, readyB}, 32'd1);
         enB = 1'b1;
         applyStimulus();
         enB = 1'b0;
         frameB = '0;
         for (int i = 0; i < BF; i++) applyStimulus();
      end
      checkOutput("t4_wordB", {24'd0, wordB}, 32'hFF);
      checkOutput("t4_countB", {29'd0, countB}, 32'd1);
      checkOutput("t4_pulsesB", 32'(bValidCount), 32'd1);

      // Randomized traffic on A.
      for (int i = 0; i < 400; i++) begin
         rstA   = ($urandom_range(0, 63) == 0);
         enA    = ($urandom_range(0, 2) != 0);
         clrA   = ($urandom_range(0, 7) == 0);
         frameA = {$urandom, $urandom};
         applyStimulus();
      end
      rstA = 1'b0; enA = 1'b0; clrA = 1'b0;
      for (int i = 0; i < AF + 2; i++) applyStimulus();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
